br_write_ctrl: RTL and testbench

BR_WRITE_CTRL -- requirements
Module: br_write_ctrl

---
 rtl/br_write_ctrl.sv | 136 +++++++++++++
 tb/tb_br_write_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_write_ctrl.sv
// Register-file writeback buffer: in-order write FIFO, youngest-wins forwarding to decode,
// and an optional post-reset zeroing sweep of registers 1..31 compiled in by BR_CLEAR_EN.
module br_write_ctrl #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_alu_data,
    input  logic [31:0] wb_mem_data,
    input  logic        wb_mem_to_reg,
    input  logic        br_hold,
    output logic [4:0]  br_address_write,
    output logic [31:0] br_data_write,
    output logic        br_enable,
    input  logic [4:0]  fwd_addr,
    output logic        fwd_hit,
    output logic [31:0] fwd_data,
    output logic        busy
);

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [AW-1:0]    addr_mem [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             out_fwd_valid;
    logic             run_c;
    logic             push_c;
    logic             pop_c;
    logic [DW-1:0]    wb_data_c;

`ifdef BR_CLEAR_EN
    typedef enum logic {CLEAR, RUN} state_t;
    state_t    state;
    logic [4:0] clr_cnt;

    assign run_c = (state == RUN);
    assign busy  = (state == CLEAR);
`else
    assign run_c = 1'b1;
    assign busy  = 1'b0;
`endif

    assign wb_ready  = run_c && (count < CNT_W'(DEPTH));
    assign wb_data_c = wb_mem_to_reg ? wb_mem_data : wb_alu_data;
    // Writes to r0 are accepted but dropped on the floor.
    assign push_c    = wb_valid && wb_ready && (wb_addr != '0);
    assign pop_c     = run_c && !br_hold && (count != '0);

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (push_c) begin
            addr_mem[wr_ptr] <= wb_addr;
            data_mem[wr_ptr] <= wb_data_c;
        end
    end

    // Pointers, count, write-port registers and the clear sweep
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            br_enable        <= 1'b0;
            br_address_write <= '0;
            br_data_write    <= '0;
            out_fwd_valid    <= 1'b0;
`ifdef BR_CLEAR_EN
            state            <= CLEAR;
            clr_cnt          <= '0;
`endif
        end else begin
            if (pop_c) begin
                br_enable        <= 1'b1;
                br_address_write <= addr_mem[rd_ptr];
                br_data_write    <= data_mem[rd_ptr];
                out_fwd_valid    <= 1'b1;
                rd_ptr           <= rd_ptr + 1'b1;
            end
`ifdef BR_CLEAR_EN
            else if ((state == CLEAR) && !br_hold) begin
                br_enable        <= 1'b1;
                br_address_write <= clr_cnt + 5'd1;
                br_data_write    <= '0;
                out_fwd_valid    <= 1'b0;
                clr_cnt          <= clr_cnt + 5'd1;
                if (clr_cnt == 5'd30) begin
                    state <= RUN;
                end
            end
`endif
            else begin
                br_enable     <= 1'b0;
                out_fwd_valid <= 1'b0;
            end

            if (push_c) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            case ({push_c, pop_c})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Scan oldest to youngest so the last match is the youngest pending write
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_addr != '0) begin
            if (out_fwd_valid && (br_address_write == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = br_data_write;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if ((CNT_W'(i) < count) &&
                    (addr_mem[PTR_W'(rd_ptr + PTR_W'(i))] == fwd_addr)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = data_mem[PTR_W'(rd_ptr + PTR_W'(i))];
                end
            end
        end
    end

endmodule

// File: tb/tb_br_write_ctrl.sv
// Scoreboard bench for br_write_ctrl: accepted writes are queued at the clock edge and a
// negedge monitor matches register-file writes, ready/busy and forwarding against that queue.
module tb_br_write_ctrl;

    localparam int DEPTH = 4;
`ifdef BR_CLEAR_EN
    localparam int CLR_START = 1;
`else
    localparam int CLR_START = 32;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_alu_data;
    logic [31:0] wb_mem_data;
    logic        wb_mem_to_reg;
    logic        br_hold;
    logic [4:0]  br_address_write;
    logic [31:0] br_data_write;
    logic        br_enable;
    logic [4:0]  fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        busy;

    br_write_ctrl #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .wb_valid         (wb_valid),
        .wb_ready         (wb_ready),
        .wb_addr          (wb_addr),
        .wb_alu_data      (wb_alu_data),
        .wb_mem_data      (wb_mem_data),
        .wb_mem_to_reg    (wb_mem_to_reg),
        .br_hold          (br_hold),
        .br_address_write (br_address_write),
        .br_data_write    (br_data_write),
        .br_enable        (br_enable),
        .fwd_addr         (fwd_addr),
        .fwd_hit          (fwd_hit),
        .fwd_data         (fwd_data),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         cur;
    bit          cur_valid;
    bit          exp_en;
    bit          started;
    int          clr_next;
    bit          m_hit;
    logic [31:0] m_data;
    int          checks;
    int          errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model update at the edge: what the write port should do, and what was accepted
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            clr_next  = CLR_START;
            exp_en    = 1'b0;
            cur_valid = 1'b0;
            started   = 1'b1;
        end else if (started) begin
            exp_en = !br_hold && ((clr_next <= 31) || (exp_q.size() > 0));
            if (wb_valid && wb_ready && (wb_addr != 5'd0)) begin
                exp_q.push_back('{wb_addr, wb_mem_to_reg ? wb_mem_data : wb_alu_data});
            end
        end
    end

    // Monitor: consume each register-file write and check the visible state
    always @(negedge clk) begin
        if (started) begin
            chk("br_enable", 32'(br_enable), 32'(exp_en));
            cur_valid = 1'b0;
            if (br_enable) begin
                if (clr_next <= 31) begin
                    chk("clear_addr", 32'(br_address_write), 32'(clr_next));
                    chk("clear_data", br_data_write, 32'd0);
                    clr_next++;
                end else if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stale_write: got write addr %0d data 0x%08h expected none at %0t",
                             br_address_write, br_data_write, $time);
                end else begin
                    cur = exp_q.pop_front();
                    chk("write_addr", 32'(br_address_write), 32'(cur.addr));
                    chk("write_data", br_data_write, cur.data);
                    cur_valid = 1'b1;
                end
            end
            chk("busy", 32'(busy), 32'(clr_next <= 31));
            chk("wb_ready", 32'(wb_ready), 32'((clr_next > 31) && (exp_q.size() < DEPTH)));

            m_hit  = 1'b0;
            m_data = 32'd0;
            if (fwd_addr != 5'd0) begin
                if (cur_valid && (cur.addr == fwd_addr)) begin
                    m_hit  = 1'b1;
                    m_data = cur.data;
                end
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (exp_q[i].addr == fwd_addr) begin
                        m_hit  = 1'b1;
                        m_data = exp_q[i].data;
                    end
                end
            end
            chk("fwd_hit", 32'(fwd_hit), 32'(m_hit));
            chk("fwd_data", fwd_data, m_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] a, input logic [31:0] d, input bit m2r);
        bit got;
        got           = 1'b0;
        wb_valid      = 1'b1;
        wb_addr       = a;
        wb_mem_to_reg = m2r;
        wb_mem_data   = m2r ? d : $urandom;
        wb_alu_data   = m2r ? $urandom : d;
        for (int n = 0; n < 100; n++) begin
            got = wb_ready;
            step();
            if (got) break;
        end
        wb_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept for addr %0d expected accept within 100 cycles", a);
        end
    endtask

    task automatic wait_not_busy();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (!busy) begin
                done = 1'b1;
                break;
            end
            step();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: got busy=1 expected 0 within 300 cycles");
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        started       = 1'b0;
        clr_next      = CLR_START;
        reset         = 1'b1;
        wb_valid      = 1'b0;
        wb_addr       = '0;
        wb_alu_data   = '0;
        wb_mem_data   = '0;
        wb_mem_to_reg = 1'b0;
        br_hold       = 1'b0;
        fwd_addr      = '0;
        step();
        step();
        reset = 1'b0;

`ifdef BR_CLEAR_EN
        // Interrupt the sweep after the tenth zeroing write; it must restart at r1
        for (int n = 0; n < 100; n++) begin
            if (clr_next >= 11) break;
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
`endif
        wait_not_busy();

        // Single ALU write, one-cycle latency, single pulse
        send(5'd5, 32'h0000_0064, 1'b0);
        step();
        chk("single_en", 32'(br_enable), 32'd1);
        chk("single_addr", 32'(br_address_write), 32'd5);
        chk("single_data", br_data_write, 32'h64);
        step();
        chk("single_en_off", 32'(br_enable), 32'd0);

        // Fill under hold, then drain in order
        br_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            send(5'(i), 32'hA + 32'(i - 1), i[0]);
        end
        chk("ready_full", 32'(wb_ready), 32'd0);
        br_hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("drain_en", 32'(br_enable), 32'd1);
            chk("drain_addr", 32'(br_address_write), 32'(i));
            chk("drain_data", br_data_write, 32'hA + 32'(i - 1));
        end
        step();
        chk("drain_en_off", 32'(br_enable), 32'd0);

        // Write to r0 is swallowed
        send(5'd0, 32'hFFFF_FFFF, 1'b0);
        fwd_addr = 5'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("r0_no_write", 32'(br_enable), 32'd0);
        end
        chk("r0_no_fwd", 32'(fwd_hit), 32'd0);

        // Youngest pending write wins forwarding
        br_hold = 1'b1;
        send(5'd7, 32'h11, 1'b0);
        send(5'd7, 32'h22, 1'b1);
        fwd_addr = 5'd7;
        #1;
        chk("fwd_young_hit", 32'(fwd_hit), 32'd1);
        chk("fwd_young_data", fwd_data, 32'h22);
        br_hold = 1'b0;
        step();
        step();
        step();
        chk("fwd_after_drain_hit", 32'(fwd_hit), 32'd0);
        chk("fwd_after_drain_data", fwd_data, 32'd0);

        // Reset with queued entries discards them
        br_hold = 1'b1;
        send(5'd9, 32'h99, 1'b0);
        send(5'd10, 32'h1010, 1'b1);
        send(5'd11, 32'h1111, 1'b0);
        br_hold = 1'b0;
        reset   = 1'b1;
        step();
        reset = 1'b0;
        chk("reset_en", 32'(br_enable), 32'd0);
`ifndef BR_CLEAR_EN
        chk("reset_ready", 32'(wb_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("reset_no_stale", 32'(br_enable), 32'd0);
        end
`endif
        wait_not_busy();

        // Random traffic with hold, r0 writes, small address range and rare resets
        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom_range(0, 499) == 0);
            wb_valid      = ($urandom_range(0, 2) != 0);
            wb_addr       = 5'($urandom_range(0, 7));
            wb_alu_data   = $urandom;
            wb_mem_data   = $urandom;
            wb_mem_to_reg = 1'($urandom_range(0, 1));
            br_hold       = ($urandom_range(0, 9) < 3);
            fwd_addr      = 5'($urandom_range(0, 7));
            step();
        end
        reset    = 1'b0;
        wb_valid = 1'b0;
        br_hold  = 1'b0;
        for (int n = 0; n < 100; n++) begin
            step();
        end
        chk("final_pending", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
